adbg_chain_sel: RTL
===================

ADBG_CHAIN_SEL -- requirements
Module: adbg_chain_sel

Interface
REQ-001 SHALL have parameter NB_MODULES, default 4, number of debug sub-modules (1..32).
REQ-002 SHALL have parameter DATA_LEN, default 53, top-level input shift register length (>= ID_WIDTH+2).
REQ-003 SHALL have parameter ID_WIDTH, default 5, module-ID field width.
REQ-004 SHALL have port tck_i  in  1  JTAG TCK, the single clock; all state on its rising edge.
REQ-005 SHALL have port trst_i  in  1  reset, synchronous and active-high.
REQ-006 SHALL have ports tdi_i  in  1  JTAG data in; tdo_o  out  1  JTAG data out.
REQ-007 SHALL have ports shift_dr_i, capture_dr_i, update_dr_i  in  1 each  TAP state strobes.
REQ-008 SHALL have port debug_select_i  in  1  debug instruction active in the TAP IR.
REQ-009 SHALL have port data_register_o  out  DATA_LEN  input shift register contents, fanned out to sub-modules.
REQ-010 SHALL have port module_select_o  out  NB_MODULES  one-hot select, all-zero when no valid module is selected.
REQ-011 SHALL have ports module_inhibit_i  in  NB_MODULES  per-module select-lock; module_tdo_i  in  NB_MODULES  per-module TDO.
REQ-012 SHALL have ports module_id_o  out  ID_WIDTH  current module ID; sel_error_o  out  1  sticky out-of-range select flag.

Function
REQ-013 SHALL shift {tdi_i, sr[DATA_LEN-1:1]} into the input shift register when debug_select_i && shift_dr_i; otherwise hold.
REQ-014 SHALL decode select_cmd = sr[DATA_LEN-1] and id_in = sr[DATA_LEN-2 : DATA_LEN-1-ID_WIDTH].
REQ-015 SHALL define select event = debug_select_i && update_dr_i && select_cmd.
REQ-016 SHALL implement a two-state FSM: SEL_ACTIVE (valid module selected), SEL_NONE (no module selected).
REQ-017 On select event with |module_inhibit_i == 1: SHALL ignore the request (state, ID, sel_error_o unchanged) and set sticky inhibit_hit.
REQ-018 On select event, not inhibited, id_in < NB_MODULES: SHALL latch module ID = id_in, go to SEL_ACTIVE, clear sel_error_o, next cycle.
REQ-019 On select event, not inhibited, id_in >= NB_MODULES: SHALL go to SEL_NONE, keep previous module ID, record id_in as last_req, set sel_error_o.
REQ-020 last_req SHALL also be updated on every accepted in-range select.
REQ-021 module_select_o SHALL be one-hot at bit module_id_o in SEL_ACTIVE, all-zero in SEL_NONE; combinational from registered state.
REQ-022 tdo_o SHALL be module_tdo_i[module_id_o] in SEL_ACTIVE, status output (REQ-028) in SEL_NONE; combinational, zero added latency.
REQ-023 Update and shift in the same cycle SHALL not occur; if it does, select decode SHALL use the pre-shift register value.
REQ-024 Clearing and setting inhibit_hit in the same cycle: set SHALL win.

Reset
REQ-025 While trst_i is high at a tck_i edge: shift register 0, module ID 0, state SEL_ACTIVE, sel_error_o 0, inhibit_hit 0, last_req 0, status register 0.
REQ-026 Post-reset outputs: module_select_o = 1 (module 0), module_id_o = 0, data_register_o = 0, tdo_o = module_tdo_i[0].
REQ-027 Reset mid-shift or mid-update SHALL discard the partial transfer; no select event is taken that cycle.

Configuration
REQ-028 With ADBG_SEL_STATUS_EN defined: an ID_WIDTH+2 status register SHALL load {inhibit_hit, last_req, 1'b1} (LSB = 1 marker) on debug_select_i && capture_dr_i in SEL_NONE, shift right with 0 fill on shift_dr_i, drive tdo_o from bit 0; the capture SHALL clear inhibit_hit.
REQ-029 Without ADBG_SEL_STATUS_EN: no status register; tdo_o SHALL be 0 in SEL_NONE; inhibit_hit SHALL still set but never clear except by reset.

Verification
REQ-030 Reset, NB_MODULES=4: shift select cmd id=2, update -> module_select_o=4'b0100, module_id_o=2, tdo_o follows module_tdo_i[2].
REQ-031 Select id=7 with NB_MODULES=4 -> module_select_o=0, sel_error_o=1, module_id_o unchanged; then select id=1 -> 4'b0010, sel_error_o=0.
REQ-032 module_inhibit_i=4'b0001 while select id=3 updates -> module_id_o stays 0, module_select_o=4'b0001, inhibit_hit=1.
REQ-033 ADBG_SEL_STATUS_EN, after REQ-031 error plus one inhibited attempt: capture then 7 shifts -> tdo_o sequence 1,1,1,1,0,0,1 (marker, id 7, inhibit_hit), then 0.
REQ-034 trst_i asserted after 20 of 53 shift bits, then released -> data_register_o=0, module_select_o=1, no select taken on following update with select_cmd=0.

Source files
------------

// File: rtl/adbg_chain_sel.sv
// adbg_chain_sel: JTAG debug chain selector with module-ID decode and TDO mux.
// Optional status readout in SEL_NONE when ADBG_SEL_STATUS_EN is defined.
//
// Ports:
//   tck_i            JTAG TCK, all state on rising edge
//   trst_i           synchronous active-high reset
//   tdi_i / tdo_o    JTAG serial data in / out
//   shift_dr_i       TAP Shift-DR strobe
//   capture_dr_i     TAP Capture-DR strobe
//   update_dr_i      TAP Update-DR strobe
//   debug_select_i   debug instruction active in IR
//   data_register_o  input shift register, fanned out to sub-modules
//   module_select_o  one-hot module select, zero when none selected
//   module_inhibit_i per-module select lock
//   module_tdo_i     per-module TDO
//   module_id_o      current module ID
//   sel_error_o      sticky out-of-range select flag
module adbg_chain_sel #(
  parameter int NB_MODULES = 4,
  parameter int DATA_LEN   = 53,
  parameter int ID_WIDTH   = 5
) (
  input  logic                  tck_i,
  input  logic                  trst_i,
  input  logic                  tdi_i,
  output logic                  tdo_o,
  input  logic                  shift_dr_i,
  input  logic                  capture_dr_i,
  input  logic                  update_dr_i,
  input  logic                  debug_select_i,
  output logic [DATA_LEN-1:0]   data_register_o,
  output logic [NB_MODULES-1:0] module_select_o,
  input  logic [NB_MODULES-1:0] module_inhibit_i,
  input  logic [NB_MODULES-1:0] module_tdo_i,
  output logic [ID_WIDTH-1:0]   module_id_o,
  output logic                  sel_error_o
);

  typedef enum logic {
    SEL_ACTIVE = 1'b0,
    SEL_NONE   = 1'b1
  } sel_state_e;

  sel_state_e            r_state;
  sel_state_e            w_state_nxt;
  logic [DATA_LEN-1:0]   r_sr;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ID_WIDTH-1:0]   w_id_nxt;
  logic [ID_WIDTH-1:0]   r_last_req;
  logic [ID_WIDTH-1:0]   w_last_nxt;
  logic                  r_sel_error;
  logic                  w_err_nxt;
  logic                  r_inhibit_hit;
  logic                  w_inh_nxt;

  logic                  w_shift;
  logic                  w_cmd;
  logic [ID_WIDTH-1:0]   w_id_in;
  logic                  w_evt;
  logic                  w_in_range;
  logic                  w_evt_inh;
  logic                  w_evt_ok;
  logic                  w_evt_bad;
  logic [NB_MODULES-1:0] w_sel;
  logic                  w_mod_tdo;
  logic                  w_stat_tdo;
  logic                  w_cap;

  assign w_shift = debug_select_i && shift_dr_i;
  assign w_cmd   = r_sr[DATA_LEN-1];
  assign w_id_in = r_sr[DATA_LEN-2 -: ID_WIDTH];
  assign w_evt   = debug_select_i && update_dr_i && w_cmd;

  // Widen before comparing: NB_MODULES=32 does not fit in ID_WIDTH.
  assign w_in_range = 32'(w_id_in) < 32'(NB_MODULES);

  assign w_evt_inh = w_evt && (|module_inhibit_i);
  assign w_evt_ok  = w_evt && !(|module_inhibit_i) && w_in_range;
  assign w_evt_bad = w_evt && !(|module_inhibit_i) && !w_in_range;

  // Decode is from the pre-shift register, so shift+update is harmless.
  always_ff @(posedge tck_i) begin
    if (trst_i) begin
      r_sr <= '0;
    end else if (w_shift) begin
      r_sr <= {tdi_i, r_sr[DATA_LEN-1:1]};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    w_err_nxt   = r_sel_error;
    w_last_nxt  = r_last_req;
    unique case (1'b1)
      w_evt_ok: begin
        w_state_nxt = SEL_ACTIVE;
        w_id_nxt    = w_id_in;
        w_err_nxt   = 1'b0;
        w_last_nxt  = w_id_in;
      end
      w_evt_bad: begin
        w_state_nxt = SEL_NONE;
        w_err_nxt   = 1'b1;
        w_last_nxt  = w_id_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge tck_i) begin
    if (trst_i) begin
      r_state     <= SEL_ACTIVE;
      r_id        <= '0;
      r_sel_error <= 1'b0;
      r_last_req  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_id        <= w_id_nxt;
      r_sel_error <= w_err_nxt;
      r_last_req  <= w_last_nxt;
    end
  end

`ifdef ADBG_SEL_STATUS_EN
  logic [ID_WIDTH+1:0] r_status;

  assign w_cap = debug_select_i && capture_dr_i &&
                 (r_state == SEL_NONE);

  always_ff @(posedge tck_i) begin
    if (trst_i) begin
      r_status <= '0;
    end else if (w_cap) begin
      r_status <= {r_inhibit_hit, r_last_req, 1'b1};
    end else if (shift_dr_i) begin
      r_status <= {1'b0, r_status[ID_WIDTH+1:1]};
    end
  end

  assign w_stat_tdo = r_status[0];
`else
  logic w_unused_cap;

  assign w_cap        = 1'b0;
  assign w_stat_tdo   = 1'b0;
  assign w_unused_cap = capture_dr_i;
`endif

  // A new inhibited request outranks a concurrent status capture.
  always_comb begin
    w_inh_nxt = r_inhibit_hit;
    if (w_evt_inh) begin
      w_inh_nxt = 1'b1;
    end else if (w_cap) begin
      w_inh_nxt = 1'b0;
    end
  end

  always_ff @(posedge tck_i) begin
    if (trst_i) begin
      r_inhibit_hit <= 1'b0;
    end else begin
      r_inhibit_hit <= w_inh_nxt;
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NB_MODULES; i++) begin
      w_sel[i] = (r_state == SEL_ACTIVE) &&
                 (r_id == ID_WIDTH'(i));
    end
  end

  assign w_mod_tdo = |(module_tdo_i & w_sel);

  assign tdo_o = (r_state == SEL_ACTIVE) ? w_mod_tdo
                                         : w_stat_tdo;

  assign data_register_o = r_sr;
  assign module_select_o = w_sel;
  assign module_id_o     = r_id;
  assign sel_error_o     = r_sel_error;

endmodule
